reg_file_pipe: RTL and testbench
================================

Name: reg_file_pipe

Overview:
- Parametrised successor to the 16x8 operand register file.
- Generic register array of 2**ADDR_W entries x DATA_W bits.
  - Registered dual read ports with same-cycle write forwarding.
  - Immediate substitution on port B.
  - Atomic double-width (hi/lo) result write for multiply/divide.
  - Sequenced bulk-clear engine with busy handshake.
- Sits between the control block/instruction decoder and the ALU; ALU results return through the write ports.

Parameters:
- DATA_W, 8: register width in bits.
- ADDR_W, 4: address width; depth = 2**ADDR_W.
- HI_ADDR, 14: register receiving the upper half of a wide write.
- LO_ADDR, 15: register receiving the lower half of a wide write.

Ports:
- CLK_In  in  1  clock; all state changes on its rising edge.
- RST_In  in  1  asynchronous, active-high reset.
- rd_valid  in  1  read request this cycle.
- Aaddr  in  ADDR_W  port-A read address.
- Baddr  in  ADDR_W  port-B read address, or immediate value when imm_sel=1.
- imm_sel  in  1  1: OperandB = zero-extended Baddr.
- Write_Enable  in  1  scalar write strobe.
- Write_addr  in  ADDR_W  scalar write address.
- Write_data  in  DATA_W  scalar write data.
- wide_we  in  1  wide write strobe (MUL/DIV result).
- wide_hi  in  DATA_W  data for HI_ADDR.
- wide_lo  in  DATA_W  data for LO_ADDR.
- clr_req  in  1  start bulk clear.
- OperandA  out  DATA_W  registered port-A data.
- OperandB  out  DATA_W  registered port-B data.
- op_valid  out  1  OperandA/B updated this cycle.
- busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when clear completes.
- wr_drop  out  1  one-cycle pulse: a scalar write was discarded.

Behaviour:
- Reset (async, RST_In=1):
  - All registers = 0; OperandA = OperandB = 0.
  - op_valid = busy = clr_done = wr_drop = 0.
  - FSM = IDLE; clear counter = 0.
- Register 0 is constant zero:
  - Writes to address 0 are silently ignored; no wr_drop.
  - Reads of address 0 return 0.
  - HI_ADDR/LO_ADDR must be nonzero.
- Read latency is 1 cycle:
  - If rd_valid=1 and busy=0 at edge N, then after edge N: OperandA = R[Aaddr], OperandB = R[Baddr] or {0, Baddr}, and op_valid=1.
  - Otherwise op_valid=0 and OperandA/B hold their previous values.
- Forwarding: a read sampled at the same edge as a write to the same nonzero address returns the new data.
  - Applies to scalar and wide writes.
  - Wide data takes precedence over scalar data.
- Write priority, evaluated in IDLE only:
  - wide_we=1: R[HI_ADDR] <= wide_hi and R[LO_ADDR] <= wide_lo at the same edge.
  - wide_we=1 with Write_Enable=1 in the same cycle: scalar write discarded, wr_drop=1.
  - wide_we=0 and Write_Enable=1: R[Write_addr] <= Write_data.
  - Reads and writes proceed concurrently.
- Immediate: with imm_sel=1, OperandB = Baddr zero-extended to DATA_W; the port-B array read is unused.
  - If DATA_W < ADDR_W, the immediate is truncated to the low DATA_W bits.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on clr_req=1.
    - Counter loads 1; busy=1 from the next cycle.
    - Read requests and writes in that same cycle are still serviced.
  - CLEAR: each cycle R[counter] <= 0, then counter++.
    - When counter = 2**ADDR_W-1 is cleared, go to DONE.
    - CLEAR lasts 2**ADDR_W-1 cycles.
  - DONE: clr_done=1 for one cycle; busy=0 and next state IDLE; requests are accepted again from the next cycle.
  - While busy=1:
    - rd_valid is ignored (op_valid=0) and OperandA/B hold.
    - wide writes are discarded.
    - Write_Enable=1 discards the scalar write and pulses wr_drop.
    - clr_req is ignored.
  - Reset mid-clear: immediate return to IDLE with all registers zero, busy=0, and no clr_done pulse.
- Counter wraps only via the DONE transition; it is never reused without a reload.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, write R3=8'hA5, then read Aaddr=3 -> OperandA=8'hA5 one cycle after rd_valid, op_valid=1 for one cycle.
- Write R5=8'h3C and read Aaddr=5 at the same edge -> OperandA=8'h3C (forwarded). Write R0=8'hFF, then read A=0 -> 8'h00, wr_drop=0.
- imm_sel=1, Baddr=4'hB -> OperandB=8'h0B. wide_we=1 with hi=8'h12, lo=8'h34, plus Write_Enable to R7 in the same cycle -> R14=8'h12, R15=8'h34, R7 unchanged, wr_drop pulse.
- Load all registers with nonzero values, pulse clr_req -> busy=1 for 15 cycles, then clr_done pulse. All reads afterwards return 0; a write attempted mid-clear is dropped with wr_drop=1.
- Assert RST_In asynchronously during CLEAR (counter=6) -> outputs 0 immediately, no clr_done. After release, a read of R9 returns 0.
- rd_valid while busy -> op_valid stays 0 and OperandA/B hold their pre-clear values.

Source files
------------

// File: rtl/reg_file_pipe.sv
// reg_file_pipe: 2**ADDR_W x DATA_W register file, registered dual read with write forwarding, immediate port B, wide hi/lo write, sequenced bulk clear
module reg_file_pipe #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int HI_ADDR = 14,
  parameter int LO_ADDR = 15
) (
  input  logic              CLK_In,
  input  logic              RST_In,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] Aaddr,
  input  logic [ADDR_W-1:0] Baddr,
  input  logic              imm_sel,
  input  logic              Write_Enable,
  input  logic [ADDR_W-1:0] Write_addr,
  input  logic [DATA_W-1:0] Write_data,
  input  logic              wide_we,
  input  logic [DATA_W-1:0] wide_hi,
  input  logic [DATA_W-1:0] wide_lo,
  input  logic              clr_req,
  output logic [DATA_W-1:0] OperandA,
  output logic [DATA_W-1:0] OperandB,
  output logic              op_valid,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_drop
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] HI = ADDR_W'(HI_ADDR);
  localparam logic [ADDR_W-1:0] LO = ADDR_W'(LO_ADDR);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] nxt [DEPTH];
  logic [DATA_W-1:0] imm;
  logic idle, rd_ok;
  assign idle     = state == IDLE;
  assign busy     = state == CLEAR;
  assign clr_done = state == DONE;
  assign rd_ok    = idle & rd_valid;
  assign imm      = DATA_W'(Baddr);
  always_ff @(posedge CLK_In or posedge RST_In)
    if (RST_In) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  always_comb begin
    state_nxt = idle && clr_req ? CLEAR :
                busy && &cnt    ? DONE  :
                clr_done        ? IDLE  : state;
    cnt_nxt   = idle && clr_req ? ADDR_W'(1) : busy ? cnt + 1'b1 : cnt;
  end
  always_comb begin
    nxt = regs;
    if (busy)
      nxt[cnt] = '0;
    else if (idle && wide_we) begin
      nxt[HI] = wide_hi;
      nxt[LO] = wide_lo;
    end else if (idle && Write_Enable)
      nxt[Write_addr] = Write_data;
    nxt[0] = '0;
  end
  always_ff @(posedge CLK_In or posedge RST_In)
    if (RST_In) begin
      regs     <= '{default: '0};
      OperandA <= '0;
      OperandB <= '0;
      op_valid <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      regs     <= nxt;
      op_valid <= rd_ok;
      wr_drop  <= Write_Enable & (wide_we | ~idle);
      if (rd_ok) begin
        OperandA <= nxt[Aaddr];
        OperandB <= imm_sel ? imm : nxt[Baddr];
      end
    end
endmodule

// File: tb/tb_reg_file_pipe.sv
// tb_reg_file_pipe: randomized and directed bench for reg_file_pipe against an array-based reference model
module tb_reg_file_pipe;
  logic       CLK_In = 1'b0, RST_In = 1'b1;
  logic       rd_valid, imm_sel, Write_Enable, wide_we, clr_req;
  logic [3:0] Aaddr, Baddr, Write_addr;
  logic [7:0] Write_data, wide_hi, wide_lo;
  logic [7:0] OperandA, OperandB;
  logic       op_valid, busy, clr_done, wr_drop;
  int tests = 0, fails = 0;
  logic [7:0] m [16];
  int   left;
  bit   done_st, ev, ed;
  logic [7:0] ea, eb;
  reg_file_pipe #(.DATA_W(8), .ADDR_W(4), .HI_ADDR(14), .LO_ADDR(15)) dut (
    .CLK_In(CLK_In), .RST_In(RST_In), .rd_valid(rd_valid), .Aaddr(Aaddr), .Baddr(Baddr),
    .imm_sel(imm_sel), .Write_Enable(Write_Enable), .Write_addr(Write_addr), .Write_data(Write_data),
    .wide_we(wide_we), .wide_hi(wide_hi), .wide_lo(wide_lo), .clr_req(clr_req),
    .OperandA(OperandA), .OperandB(OperandB), .op_valid(op_valid), .busy(busy),
    .clr_done(clr_done), .wr_drop(wr_drop)
  );
  always #5 CLK_In = ~CLK_In;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic quiet();
    {rd_valid, imm_sel, Write_Enable, wide_we, clr_req} = '0;
    {Aaddr, Baddr, Write_addr} = '0;
    {Write_data, wide_hi, wide_lo} = '0;
  endtask
  task automatic model_reset();
    foreach (m[i]) m[i] = '0;
    left = 0;
    done_st = 0;
    ev = 0;
    ed = 0;
    ea = '0;
    eb = '0;
  endtask
  task automatic step();
    ev = 0;
    ed = 0;
    if (done_st) begin
      done_st = 0;
      ed = Write_Enable;
    end else if (left > 0) begin
      left--;
      done_st = left == 0;
      ed = Write_Enable;
    end else begin
      if (wide_we) begin
        m[14] = wide_hi;
        m[15] = wide_lo;
        ed = Write_Enable;
      end else if (Write_Enable && Write_addr != 0)
        m[Write_addr] = Write_data;
      if (rd_valid) begin
        ev = 1;
        ea = m[Aaddr];
        eb = imm_sel ? {4'h0, Baddr} : m[Baddr];
      end
      if (clr_req) begin
        left = 15;
        foreach (m[i]) m[i] = '0;
      end
    end
    @(posedge CLK_In);
    #1;
    check("op_valid", op_valid, ev);
    check("wr_drop", wr_drop, ed);
    check("busy", busy, left > 0);
    check("clr_done", clr_done, done_st);
    check("OperandA", OperandA, ea);
    check("OperandB", OperandB, eb);
  endtask
  task automatic fill();
    for (int i = 1; i < 16; i++) begin
      quiet();
      Write_Enable = 1;
      Write_addr = 4'(i);
      Write_data = 8'(i * 16 + i);
      step();
    end
  endtask
  initial begin
    int bc;
    quiet();
    model_reset();
    #2;
    check("rst_opa", OperandA, 0);
    check("rst_busy", busy, 0);
    check("rst_opv", op_valid, 0);
    @(negedge CLK_In);
    RST_In = 0;
    quiet(); Write_Enable = 1; Write_addr = 3; Write_data = 8'hA5; step();
    quiet(); rd_valid = 1; Aaddr = 3; step();
    check("rd_r3", OperandA, 8'hA5);
    check("rd_r3_v", op_valid, 1);
    quiet(); step();
    check("opv_pulse", op_valid, 0);
    quiet(); Write_Enable = 1; Write_addr = 5; Write_data = 8'h3C; rd_valid = 1; Aaddr = 5; step();
    check("fwd_r5", OperandA, 8'h3C);
    quiet(); Write_Enable = 1; Write_addr = 0; Write_data = 8'hFF; step();
    check("r0_nodrop", wr_drop, 0);
    quiet(); rd_valid = 1; Aaddr = 0; step();
    check("r0_zero", OperandA, 0);
    quiet(); rd_valid = 1; imm_sel = 1; Baddr = 4'hB; step();
    check("imm", OperandB, 8'h0B);
    quiet(); Write_Enable = 1; Write_addr = 7; Write_data = 8'h55; step();
    quiet(); wide_we = 1; wide_hi = 8'h12; wide_lo = 8'h34; Write_Enable = 1; Write_addr = 7; Write_data = 8'h99; step();
    check("wide_drop", wr_drop, 1);
    quiet(); rd_valid = 1; Aaddr = 14; Baddr = 15; step();
    check("wide_hi", OperandA, 8'h12);
    check("wide_lo", OperandB, 8'h34);
    quiet(); rd_valid = 1; Aaddr = 7; step();
    check("r7_kept", OperandA, 8'h55);
    quiet(); wide_we = 1; wide_hi = 8'hC1; wide_lo = 8'hC2; Write_Enable = 1; Write_addr = 14; Write_data = 8'hEE;
    rd_valid = 1; Aaddr = 14; Baddr = 15; step();
    check("wide_fwd_prec", OperandA, 8'hC1);
    fill();
    quiet(); rd_valid = 1; Aaddr = 9; Baddr = 12; step();
    check("pre_clr", OperandA, 8'h99);
    quiet(); clr_req = 1; step();
    bc = busy ? 1 : 0;
    for (int i = 0; i < 14; i++) begin
      quiet();
      if (i == 3) begin rd_valid = 1; Aaddr = 2; Write_Enable = 1; Write_addr = 2; Write_data = 8'h77; end
      if (i == 5) begin wide_we = 1; wide_hi = 8'hAA; clr_req = 1; end
      step();
      if (busy) bc++;
      if (i == 3) begin
        check("clr_drop", wr_drop, 1);
        check("clr_hold", OperandA, 8'h99);
      end
    end
    check("busy_len", bc, 15);
    quiet(); step();
    check("clr_done_pulse", clr_done, 1);
    for (int i = 0; i < 16; i++) begin
      quiet(); rd_valid = 1; Aaddr = 4'(i); Baddr = 4'(15 - i); step();
    end
    fill();
    quiet(); clr_req = 1; step();
    for (int i = 0; i < 5; i++) begin quiet(); step(); end
    #2;
    RST_In = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", clr_done, 0);
    check("mid_rst_opa", OperandA, 0);
    check("mid_rst_opb", OperandB, 0);
    check("mid_rst_opv", op_valid, 0);
    model_reset();
    @(negedge CLK_In);
    RST_In = 0;
    for (int i = 0; i < 20; i++) begin quiet(); step(); end
    quiet(); rd_valid = 1; Aaddr = 9; step();
    check("r9_after_rst", OperandA, 0);
    for (int i = 0; i < 600; i++) begin
      quiet();
      if (!done_st) begin
        rd_valid     = $urandom_range(0, 1);
        imm_sel      = $urandom_range(0, 3) == 0;
        Aaddr        = 4'($urandom);
        Baddr        = 4'($urandom);
        Write_Enable = $urandom_range(0, 1);
        Write_addr   = 4'($urandom);
        Write_data   = 8'($urandom);
        wide_we      = $urandom_range(0, 5) == 0;
        wide_hi      = 8'($urandom);
        wide_lo      = 8'($urandom);
        clr_req      = $urandom_range(0, 59) == 0;
        if (wide_we && Write_addr == 0) Write_addr = 1;
      end
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
